// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - RV64M multi-cycle multiply/divide sequencer (shift-add multiply, restoring divide).
// Optional MD_ZERO_SKIP_EN: multiplies with a zero operand finish on the one-cycle special path.
module md_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic            is_word,
  input  logic [XLEN-1:0] op1_data,
  input  logic [XLEN-1:0] op2_data,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    f3_q, f3_d;
  logic          word_q, word_d;
  logic          neg_q, neg_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d;
  logic [63:0]   lo_q, lo_d;
  logic [63:0]   mcand_q, mcand_d;
  logic [63:0]   result_q, result_d;

  logic          is_mul, is_rem, sgn1, sgn2, s1, s2;
  logic [63:0]   op1_sx, op2_sx, ext1, ext2, mag1, mag2;
  logic          div_zero, div_ovf, mul_zero, special;
  logic [63:0]   spec_res;

  // Operand extraction, sign-to-magnitude and special-case detection for the issuing op
  always_comb begin
    is_mul = ~funct3[2];
    is_rem = funct3[1];
    if (is_mul) begin
      sgn1 = is_word | (funct3[1:0] != 2'b11);
      sgn2 = is_word | ~funct3[1];
    end else begin
      sgn1 = ~funct3[0];
      sgn2 = ~funct3[0];
    end
    op1_sx = {{32{op1_data[31]}}, op1_data[31:0]};
    op2_sx = {{32{op2_data[31]}}, op2_data[31:0]};
    ext1   = is_word ? (sgn1 ? op1_sx : {32'b0, op1_data[31:0]}) : op1_data;
    ext2   = is_word ? (sgn2 ? op2_sx : {32'b0, op2_data[31:0]}) : op2_data;
    s1     = sgn1 & ext1[63];
    s2     = sgn2 & ext2[63];
    mag1   = s1 ? -ext1 : ext1;
    mag2   = s2 ? -ext2 : ext2;

    div_zero = ~is_mul & (ext2 == 64'd0);
    div_ovf  = ~is_mul & ~funct3[0] & (ext2 == '1) &
               (ext1 == (is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
`ifdef MD_ZERO_SKIP_EN
    mul_zero = is_mul & ((ext1 == 64'd0) | (ext2 == 64'd0));
`else
    mul_zero = 1'b0;
`endif
    special = div_zero | div_ovf | mul_zero;

    spec_res = 64'd0;
    if (div_zero) begin
      spec_res = is_rem ? (is_word ? op1_sx : ext1) : '1;
    end else if (div_ovf) begin
      spec_res = is_rem ? 64'd0 : ext1;
    end
  end

  logic [64:0]   mul_sum;
  logic [64:0]   div_sh;
  logic          div_ge;
  logic [63:0]   div_diff;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : 65'd0);
    div_sh   = {acc_q, lo_q[63]};
    div_ge   = div_sh[64] | (div_sh[63:0] >= mcand_q);
    div_diff = div_sh[63:0] - mcand_q;
  end

  logic [127:0]  prod, prod_n;
  logic [31:0]   wprod_n;
  logic [63:0]   dsel, dsel_n;
  logic [63:0]   fix_res;

  // Result sign and width are applied once, after the last iteration
  always_comb begin
    prod    = {acc_q, lo_q};
    prod_n  = neg_q ? -prod : prod;
    wprod_n = neg_q ? -lo_q[63:32] : lo_q[63:32];
    dsel    = f3_q[1] ? acc_q : lo_q;
    dsel_n  = neg_q ? -dsel : dsel;
    if (~f3_q[2]) begin
      if (word_q) fix_res = {{32{wprod_n[31]}}, wprod_n};
      else        fix_res = (f3_q[1:0] == 2'b00) ? prod_n[63:0] : prod_n[127:64];
    end else begin
      fix_res = word_q ? {{32{dsel_n[31]}}, dsel_n[31:0]} : dsel_n;
    end
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    word_d   = word_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        ready   = 1'b1;
        busy    = (state_q == S_DONE);
        done    = (state_q == S_DONE);
        state_d = S_IDLE;
        if (start && !flush) begin
          f3_d   = funct3;
          word_d = is_word;
          neg_d  = (is_mul || !is_rem) ? (s1 ^ s2) : s1;
          cnt_d  = is_word ? 6'd31 : 6'd63;
          acc_d  = 64'd0;
          if (is_mul) begin
            lo_d    = mag2;
            mcand_d = mag1;
          end else begin
            lo_d    = is_word ? {mag1[31:0], 32'd0} : mag1;
            mcand_d = mag2;
          end
          if (special) begin
            state_d  = S_DONE;
            result_d = spec_res;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (~f3_q[2]) begin
            acc_d = mul_sum[64:1];
            lo_d  = {mul_sum[0], lo_q[63:1]};
          end else begin
            acc_d = div_ge ? div_diff : div_sh[63:0];
            lo_d  = {lo_q[62:0], div_ge};
          end
          if (cnt_q == 6'd0) state_d = S_FIX;
          else               cnt_d   = cnt_q - 6'd1;
        end
      end
      S_FIX: begin
        busy = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_DONE;
          result_d = fix_res;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      f3_q     <= 3'd0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      lo_q     <= 64'd0;
      mcand_q  <= 64'd0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - directed vector bench for md_sequencer.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic        is_word = 1'b0;
  logic [63:0] op1_data = 64'd0;
  logic [63:0] op2_data = 64'd0;
  logic        flush = 1'b0;
  logic        ready, busy, done;
  logic [63:0] result;

  always #5 clk = ~clk;

  md_sequencer #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .is_word(is_word),
    .op1_data(op1_data), .op2_data(op2_data), .flush(flush),
    .ready(ready), .busy(busy), .done(done), .result(result)
  );

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the op is sampled on the following posedge.
  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
    start    = 1'b1;
    funct3   = f3;
    is_word  = w;
    op1_data = a;
    op2_data = b;
    @(posedge clk);
  endtask

  // Returns k = number of negedges after the issuing edge until done is seen (-1 on timeout).
  task automatic wait_done(output int lat, output logic [63:0] res, output logic busy_ok);
    lat     = -1;
    res     = 64'd0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start    = 1'b0;
        op1_data = ~op1_data;
        op2_data = ~op2_data;
        funct3   = funct3 ^ 3'b101;
        is_word  = ~is_word;
      end
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = k;
        res = result;
        break;
      end
    end
  endtask

  int          lat;
  logic [63:0] res;
  logic        bok;
  logic        saw_done;
  int          zlat;

  initial begin
`ifdef MD_ZERO_SKIP_EN
    zlat = 1;
`else
    zlat = 66;
`endif
    vecs.push_back('{"mul_7_m3",     3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66});
    vecs.push_back('{"mulhu_ones",   3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66});
    vecs.push_back('{"mulh_ones",    3'b001, 1'b0, '1, '1, 64'd0, 66});
    vecs.push_back('{"mulhsu_m1_2",  3'b010, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66});
    vecs.push_back('{"div_m7_2",     3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66});
    vecs.push_back('{"rem_m7_2",     3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66});
    vecs.push_back('{"rem_7_m2",     3'b110, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66});
    vecs.push_back('{"remu_ones_10", 3'b111, 1'b0, '1, 64'd10, 64'd5, 66});
    vecs.push_back('{"divw_m7_2",    3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34});
    vecs.push_back('{"mulw_16_m1",   3'b000, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF0, 34});
    vecs.push_back('{"mulhw_as_mulw",3'b001, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF0, 34});
    vecs.push_back('{"remuw",        3'b111, 1'b1, 64'hABCD_0000_8000_0003, 64'h10, 64'd3, 34});
    vecs.push_back('{"divuw_sext",   3'b101, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 34});
    vecs.push_back('{"divu_by0",     3'b101, 1'b0, 64'd100, 64'd0, '1, 1});
    vecs.push_back('{"rem_by0",      3'b110, 1'b0, 64'd100, 64'd0, 64'd100, 1});
    vecs.push_back('{"div_ovf",      3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1});
    vecs.push_back('{"rem_ovf",      3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1});
    vecs.push_back('{"divw_ovf",     3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{"remw_by0",     3'b110, 1'b1, 64'h0000_0000_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1});
    vecs.push_back('{"mul_5_0",      3'b000, 1'b0, 64'd5, 64'd0, 64'd0, zlat});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {63'd0, ready}, 64'd1);
    check("reset_busy",  {63'd0, busy},  64'd0);
    check("reset_done",  {63'd0, done},  64'd0);
    check("reset_result", result, 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      issue(vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b);
      wait_done(lat, res, bok);
      check({vecs[i].name, "_result"}, res, vecs[i].res);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      check({vecs[i].name, "_busy"}, {63'd0, bok}, 64'd1);
    end

    // Flush a DIV at edge t+10; last committed result was 0 (mul_5_0)
    @(negedge clk);
    issue(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    saw_done = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) saw_done = 1'b1;
      if (k == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_low", {63'd0, busy}, 64'd0);
    check("flush_no_done", {63'd0, saw_done | done}, 64'd0);
    check("flush_result_hold", result, 64'd0);
    issue(3'b110, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_done(lat, res, bok);
    check("post_flush_result", res, 64'd1);
    check("post_flush_latency", 64'(lat), 64'd66);

    // Start while busy is ignored
    @(negedge clk);
    issue(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 4) begin
        start = 1'b1; funct3 = 3'b101; op1_data = 64'd100; op2_data = 64'd0;
      end
      if (k == 5) start = 1'b0;
      if (done) begin
        lat = k;
        res = result;
        break;
      end
    end
    check("ignore_start_latency", 64'(lat), 64'd66);
    check("ignore_start_result", res, 64'hFFFF_FFFF_FFFF_FFEB);
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("ignore_start_no_extra_done", {63'd0, saw_done}, 64'd0);

    // Back-to-back: second op issued in the first DONE cycle
    @(negedge clk);
    issue(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_done(lat, res, bok);
    check("b2b_first_latency", 64'(lat), 64'd66);
    check("b2b_ready_in_done", {63'd0, ready}, 64'd1);
    issue(3'b011, 1'b0, '1, '1);
    wait_done(lat, res, bok);
    check("b2b_second_latency", 64'(lat), 64'd66);
    check("b2b_second_result", res, 64'hFFFF_FFFF_FFFF_FFFE);

    // Asynchronous reset mid-operation
    @(negedge clk);
    issue(3'b100, 1'b0, 64'd1000, 64'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_busy",   {63'd0, busy},  64'd0);
    check("mid_reset_ready",  {63'd0, ready}, 64'd1);
    check("mid_reset_done",   {63'd0, done},  64'd0);
    check("mid_reset_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
